mux_32_1_tdm_scanner: RTL and testbench



---
 rtl/mux_32_1_tdm_scanner_if.sv | 38 +++
 rtl/mux_32_1_tdm_scanner.sv | 146 ++++++++++++++
 tb/tb_mux_32_1_tdm_scanner.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_32_1_tdm_scanner_if.sv
// Beat-stream bundle between the 32:1 TDM scanner (master) and its consumer (slave).
// MUX_CHANNEL_MASK_EN adds the Mask_In channel-skip vector.
interface mux_32_1_tdm_scanner_if #(
    parameter int unsigned NUM_CH    = 32,
    parameter int unsigned SEL_WIDTH = 5
);
    logic                 Enable_In;
    logic [NUM_CH-1:0]    Data_In;
    logic                 Ready_In;
`ifdef MUX_CHANNEL_MASK_EN
    logic [NUM_CH-1:0]    Mask_In;
`endif
    logic                 Valid_Out;
    logic                 Data_Out;
    logic [SEL_WIDTH-1:0] Select_Out;
    logic                 Frame_Start_Out;
    logic                 Frame_Done_Out;

`ifdef MUX_CHANNEL_MASK_EN
    modport master (
        input  Enable_In, Data_In, Ready_In, Mask_In,
        output Valid_Out, Data_Out, Select_Out, Frame_Start_Out, Frame_Done_Out
    );
    modport slave (
        output Enable_In, Data_In, Ready_In, Mask_In,
        input  Valid_Out, Data_Out, Select_Out, Frame_Start_Out, Frame_Done_Out
    );
`else
    modport master (
        input  Enable_In, Data_In, Ready_In,
        output Valid_Out, Data_Out, Select_Out, Frame_Start_Out, Frame_Done_Out
    );
    modport slave (
        output Enable_In, Data_In, Ready_In,
        input  Valid_Out, Data_Out, Select_Out, Frame_Start_Out, Frame_Done_Out
    );
`endif
endinterface

// File: rtl/mux_32_1_tdm_scanner.sv
// Sequential NUM_CH:1 TDM scanner: one valid/ready beat {bit, index} per channel, in index order.
// Define MUX_CHANNEL_MASK_EN to add Mask_In, which skips masked channels.
module mux_32_1_tdm_scanner #(
    parameter int unsigned NUM_CH       = 32,
    parameter int unsigned SEL_WIDTH    = 5,
    parameter int unsigned DWELL_CYCLES = 0
) (
    input logic                    Clock_In,
    input logic                    Reset_N_In,
    mux_32_1_tdm_scanner_if.master bus
);
    localparam int unsigned DwellW    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned DwellLast = (DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StLoad, StHold, StWait} state_e;

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] ch_q, ch_d;
    logic [DwellW-1:0]    dwell_q, dwell_d;
    logic                 valid_q, valid_d;
    logic                 data_q, data_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 fs_q, fs_d;
    logic                 fd_q, fd_d;
    logic                 last_q, last_d;

    logic [NUM_CH-1:0]    mask;
    logic [SEL_WIDTH-1:0] load_ch, lo_ch, hi_ch;
    logic                 any_ch;

`ifdef MUX_CHANNEL_MASK_EN
    assign mask = bus.Mask_In;
`else
    assign mask = '0;
`endif

    assign any_ch = ~&mask;

    // load_ch: first unmasked index at or after ch_q (wrapping); lo/hi bound the frame.
    always_comb begin
        logic [SEL_WIDTH-1:0] cand;
        cand    = '0;
        load_ch = ch_q;
        lo_ch   = '0;
        hi_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = ch_q + SEL_WIDTH'(i);
            if (!mask[cand]) load_ch = cand;
            if (!mask[i]) lo_ch = SEL_WIDTH'(i);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!mask[i]) hi_ch = SEL_WIDTH'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dwell_d = dwell_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        fs_d    = fs_q;
        last_d  = last_q;
        fd_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Enable_In && any_ch) state_d = StLoad;
            end
            StLoad: begin
                if (any_ch) begin
                    data_d  = bus.Data_In[load_ch];
                    sel_d   = load_ch;
                    valid_d = 1'b1;
                    fs_d    = (load_ch == lo_ch);
                    // Captured here so a later mask change cannot retarget the held beat.
                    last_d  = (load_ch == hi_ch);
                    state_d = StHold;
                end else begin
                    ch_d    = '0;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (bus.Ready_In) begin
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                    fd_d    = last_q;
                    ch_d    = sel_q + 1'b1;
                    if (DWELL_CYCLES > 0) begin
                        dwell_d = '0;
                        state_d = StWait;
                    end else if (bus.Enable_In) begin
                        state_d = StLoad;
                    end else begin
                        ch_d    = '0;
                        state_d = StIdle;
                    end
                end
            end
            StWait: begin
                if (dwell_q == DwellW'(DwellLast)) begin
                    if (bus.Enable_In) begin
                        state_d = StLoad;
                    end else begin
                        ch_d    = '0;
                        state_d = StIdle;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= StIdle;
            ch_q    <= '0;
            dwell_q <= '0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            sel_q   <= '0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dwell_q <= dwell_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            last_q  <= last_d;
        end
    end

    assign bus.Valid_Out       = valid_q;
    assign bus.Data_Out        = data_q;
    assign bus.Select_Out      = sel_q;
    assign bus.Frame_Start_Out = fs_q;
    assign bus.Frame_Done_Out  = fd_q;
endmodule

// File: tb/tb_mux_32_1_tdm_scanner.sv
// Bench for mux_32_1_tdm_scanner: directed and random stimulus against a beat-stream model.
// A second instance with DWELL_CYCLES=3 runs alongside with Enable/Ready held high.
`timescale 1ns/1ps
module tb_mux_32_1_tdm_scanner;
    localparam int NumCh = 32;
    localparam int SelW  = 5;
    localparam int Dwell = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        rdy   = 1'b0;
    logic [31:0] din   = 32'hA5A5_0F0F;
    logic [31:0] mask  = '0;

    int n_checks = 0;
    int n_errors = 0;
    int beats    = 0;
    int dones    = 0;
    int d_beats  = 0;

    always #5 clk = ~clk;

    mux_32_1_tdm_scanner_if #(.NUM_CH(NumCh), .SEL_WIDTH(SelW)) bus0 ();
    mux_32_1_tdm_scanner_if #(.NUM_CH(NumCh), .SEL_WIDTH(SelW)) bus1 ();

    assign bus0.Enable_In = en;
    assign bus0.Ready_In  = rdy;
    assign bus0.Data_In   = din;
    assign bus1.Enable_In = 1'b1;
    assign bus1.Ready_In  = 1'b1;
    assign bus1.Data_In   = din;
`ifdef MUX_CHANNEL_MASK_EN
    assign bus0.Mask_In   = mask;
    assign bus1.Mask_In   = '0;
`endif

    mux_32_1_tdm_scanner #(
        .NUM_CH(NumCh), .SEL_WIDTH(SelW), .DWELL_CYCLES(0)
    ) u_dut (
        .Clock_In(clk), .Reset_N_In(rst_n), .bus(bus0)
    );

    mux_32_1_tdm_scanner #(
        .NUM_CH(NumCh), .SEL_WIDTH(SelW), .DWELL_CYCLES(Dwell)
    ) u_dut_dwell (
        .Clock_In(clk), .Reset_N_In(rst_n), .bus(bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: first channel at or after start (wrapping) whose mask bit is clear, -1 if none.
    function automatic int first_free_from(input int start, input logic [31:0] m);
        for (int k = 0; k < NumCh; k++) begin
            if (!m[(start + k) % NumCh]) return (start + k) % NumCh;
        end
        return -1;
    endfunction

    function automatic int last_free(input logic [31:0] m);
        for (int k = NumCh - 1; k >= 0; k--) begin
            if (!m[k]) return k;
        end
        return -1;
    endfunction

    // Stream monitor for the back-to-back instance; observes at the falling edge.
    initial begin : mon_main
        logic p_valid, p_fs, p_data, p_last, restart, xfer, v;
        int   p_sel, next_ch, es;
        p_valid = 1'b0; p_fs = 1'b0; p_data = 1'b0; p_last = 1'b0; restart = 1'b1;
        p_sel = 0; next_ch = 0;
        forever begin
            @(negedge clk);
            v = bus0.Valid_Out;
            if (!rst_n) begin
                p_valid = 1'b0;
                p_last  = 1'b0;
                restart = 1'b1;
            end else begin
                // Ready now is what the DUT saw at the edge just past.
                xfer = p_valid && rdy;
                if (xfer) begin
                    next_ch = (p_sel + 1) % NumCh;
                    if (!en) restart = 1'b1;
                end
                check_eq("frame_done", bus0.Frame_Done_Out, xfer && p_last);
                if (bus0.Frame_Done_Out) dones++;
                if (p_valid && !xfer) begin
                    check_eq("hold_valid", v, 1'b1);
                    check_eq("hold_sel", bus0.Select_Out, p_sel);
                    check_eq("hold_data", bus0.Data_Out, p_data);
                    check_eq("hold_frame_start", bus0.Frame_Start_Out, p_fs);
                end else if (v) begin
                    es = restart ? first_free_from(0, mask) : first_free_from(next_ch, mask);
                    if (es < 0) begin
                        check_eq("beat_while_all_masked", v, 1'b0);
                    end else begin
                        check_eq("beat_sel", bus0.Select_Out, es);
                        check_eq("beat_data", bus0.Data_Out, din[es]);
                        check_eq("beat_frame_start", bus0.Frame_Start_Out,
                                 es == first_free_from(0, mask));
                        p_last = (es == last_free(mask));
                    end
                    restart = 1'b0;
                    beats++;
                end else begin
                    check_eq("idle_frame_start", bus0.Frame_Start_Out, 1'b0);
                end
                if (&mask) restart = 1'b1;
                p_valid = v;
                p_sel   = int'(bus0.Select_Out);
                p_data  = bus0.Data_Out;
                p_fs    = bus0.Frame_Start_Out;
            end
        end
    end

    // Dwell instance: every beat accepted at once, then Dwell WAIT cycles plus one LOAD cycle.
    initial begin : mon_dwell
        int nxt, gap;
        bit have, last_seen;
        nxt = 0; gap = 0; have = 1'b0; last_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nxt = 0; gap = 0; have = 1'b0; last_seen = 1'b0;
            end else begin
                check_eq("dwell_frame_done", bus1.Frame_Done_Out, last_seen);
                last_seen = 1'b0;
                if (bus1.Valid_Out) begin
                    check_eq("dwell_sel", bus1.Select_Out, nxt);
                    check_eq("dwell_data", bus1.Data_Out, din[nxt]);
                    check_eq("dwell_frame_start", bus1.Frame_Start_Out, nxt == 0);
                    if (have) check_eq("dwell_gap", gap, Dwell + 1);
                    last_seen = (nxt == NumCh - 1);
                    nxt  = (nxt + 1) % NumCh;
                    have = 1'b1;
                    gap  = 0;
                    d_beats++;
                end else begin
                    gap++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_sel(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (bus0.Valid_Out && int'(bus0.Select_Out) == target) ok = 1'b1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, bus0.Valid_Out, 1'b0);
        check_eq({tag, "_data"}, bus0.Data_Out, 1'b0);
        check_eq({tag, "_sel"}, bus0.Select_Out, 0);
        check_eq({tag, "_frame_start"}, bus0.Frame_Start_Out, 1'b0);
        check_eq({tag, "_frame_done"}, bus0.Frame_Done_Out, 1'b0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1);
    end

    initial begin : stim
        bit ok;
        int seen1, seen3, seen_other;

        #3;
        check_quiet("reset");
        tick();
        rst_n = 1'b1; en = 1'b1; rdy = 1'b1;

        // Full scan of a fixed pattern: latency 2 edges, then one beat per 2 cycles.
        tick();
        check_eq("t1_latency_edge1_valid", bus0.Valid_Out, 1'b0);
        tick();
        check_eq("t1_first_valid", bus0.Valid_Out, 1'b1);
        check_eq("t1_first_sel", bus0.Select_Out, 0);
        check_eq("t1_first_frame_start", bus0.Frame_Start_Out, 1'b1);
        repeat (70) tick();
        check_eq("t1_beat_count", beats, 36);
        check_eq("t1_frame_done_count", dones, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            din = $urandom;
            rdy = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 15) != 0);
            tick();
        end

        // Stall on channel 7 while its input toggles.
        en = 1'b0; rdy = 1'b1;
        repeat (4) tick();
        din = 32'hA5A5_0F0F; en = 1'b1;
        wait_sel(7, 80, ok);
        check_eq("t2_reach_sel7", ok, 1'b1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din[7] = ~din[7];
            tick();
            check_eq("t2_frozen_valid", bus0.Valid_Out, 1'b1);
            check_eq("t2_frozen_sel", bus0.Select_Out, 7);
            check_eq("t2_frozen_data", bus0.Data_Out, 1'b0);
        end
        rdy = 1'b1;

        // Enable dropped while channel 12 is held.
        wait_sel(12, 80, ok);
        check_eq("t3_reach_sel12", ok, 1'b1);
        rdy = 1'b0; en = 1'b0;
        repeat (2) tick();
        check_eq("t3_still_valid", bus0.Valid_Out, 1'b1);
        check_eq("t3_still_sel", bus0.Select_Out, 12);
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_idle_valid", bus0.Valid_Out, 1'b0);
        end
        en = 1'b1;
        tick();
        check_eq("t3_reenable_edge1_valid", bus0.Valid_Out, 1'b0);
        tick();
        check_eq("t3_reenable_valid", bus0.Valid_Out, 1'b1);
        check_eq("t3_reenable_sel", bus0.Select_Out, 0);
        check_eq("t3_reenable_frame_start", bus0.Frame_Start_Out, 1'b1);

        // Asynchronous reset in the middle of channel 20's hold.
        wait_sel(20, 100, ok);
        check_eq("t4_reach_sel20", ok, 1'b1);
        rdy = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_quiet("t4_async_reset");
        repeat (2) tick();
        rst_n = 1'b1; rdy = 1'b1; en = 1'b1;
        tick();
        check_eq("t4_restart_edge1_valid", bus0.Valid_Out, 1'b0);
        tick();
        check_eq("t4_restart_valid", bus0.Valid_Out, 1'b1);
        check_eq("t4_restart_sel", bus0.Select_Out, 0);
        repeat (30) tick();

`ifdef MUX_CHANNEL_MASK_EN
        en = 1'b0;
        repeat (4) tick();
        mask = 32'hFFFF_FFF5; en = 1'b1;
        seen1 = 0; seen3 = 0; seen_other = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus0.Valid_Out) begin
                if (bus0.Select_Out == 5'd1) seen1++;
                else if (bus0.Select_Out == 5'd3) seen3++;
                else seen_other++;
            end
        end
        check_eq("t6_seen_ch1", seen1 > 0, 1'b1);
        check_eq("t6_seen_ch3", seen3 > 0, 1'b1);
        check_eq("t6_seen_masked", seen_other, 0);
        mask = '1;
        repeat (6) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t6_all_masked_valid", bus0.Valid_Out, 1'b0);
        end
        mask = '0;
        repeat (20) tick();
`else
        seen1 = 0; seen3 = 0; seen_other = 0;
`endif

        check_eq("t5_dwell_beats_seen", d_beats > 20, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
